// File: rtl/cpu_pkg.sv
// Shared core definitions: data width, write-back source encodings, load funct3
// codes and the MEM/WB stage register layout.
package cpu_pkg;

   localparam int unsigned XLEN = 32;

   // Write-back source select
   localparam logic [1:0] WB_ALU = 2'b00;
   localparam logic [1:0] WB_MEM = 2'b01;
   localparam logic [1:0] WB_PC4 = 2'b10;
   localparam logic [1:0] WB_IMM = 2'b11;

   // Load funct3 codes
   localparam logic [2:0] LD_B  = 3'b000;
   localparam logic [2:0] LD_H  = 3'b001;
   localparam logic [2:0] LD_W  = 3'b010;
   localparam logic [2:0] LD_BU = 3'b100;
   localparam logic [2:0] LD_HU = 3'b101;

   typedef struct packed {
      logic            valid;
      logic            wr_en;
      logic [4:0]      rd;
      logic [1:0]      wb_sel;
      logic [XLEN-1:0] alu_res;
      logic [XLEN-1:0] mem_rdata;
      logic [XLEN-1:0] pc;
      logic [XLEN-1:0] imm;
      logic [2:0]      ld_funct3;
   } mem_wb_t;

endpackage

// File: rtl/load_ext.sv
// Load alignment and extension (purely combinational).
// Ports:
//   raw_i    - raw 32-bit word from data memory
//   addr_i   - low address bits; byte lane = addr_i, half lane = addr_i[1]
//   funct3_i - load type (LB/LH/LW/LBU/LHU; unknown codes return the full word)
//   data_o   - aligned, extended load data
module load_ext
   import cpu_pkg::*;
(
   input  logic [XLEN-1:0] raw_i,
   input  logic [1:0]      addr_i,
   input  logic [2:0]      funct3_i,
   output logic [XLEN-1:0] data_o
);

   logic [7:0]  byte_sel;
   logic [15:0] half_sel;

   always_comb begin
      byte_sel = raw_i[7:0];
      unique case (addr_i)
         2'd0: byte_sel = raw_i[7:0];
         2'd1: byte_sel = raw_i[15:8];
         2'd2: byte_sel = raw_i[23:16];
         2'd3: byte_sel = raw_i[31:24];
         default: byte_sel = raw_i[7:0];
      endcase
      // Halfword alignment ignores address bit 0
      half_sel = addr_i[1] ? raw_i[31:16] : raw_i[15:0];
   end

   always_comb begin
      data_o = raw_i;
      case (funct3_i)
         LD_B:    data_o = {{24{byte_sel[7]}}, byte_sel};
         LD_BU:   data_o = {24'd0, byte_sel};
         LD_H:    data_o = {{16{half_sel[15]}}, half_sel};
         LD_HU:   data_o = {16'd0, half_sel};
         default: data_o = raw_i;
      endcase
   end

endmodule

// File: rtl/mem_wb_stage.sv
// MEM/WB pipeline register and write-back unit. Latches memory-stage results,
// extends load data, selects the write-back value and drives the register file
// write port plus an identical forwarding copy. All outputs come from registered
// state only.
// Ports:
//   clk_i, rst_i (synchronous, active-high)
//   stall_i / flush_i       - hold stage / replace incoming entry with a bubble
//   valid_i .. ld_funct3_i  - MEM-stage entry fields
//   rf_we_o/rf_wr_o/rf_wd_o - register file write port
//   wb_valid_o              - stage holds a valid entry
//   fwd_we_o/fwd_rd_o/fwd_data_o - forwarding copy of the RF write
//   retire_cnt_o            - 64-bit retired count, only with MEM_WB_RETIRE_CNT_EN
module mem_wb_stage
   import cpu_pkg::*;
(
   input  logic            clk_i,
   input  logic            rst_i,
   input  logic            stall_i,
   input  logic            flush_i,
   input  logic            valid_i,
   input  logic            wr_en_i,
   input  logic [4:0]      rd_i,
   input  logic [1:0]      wb_sel_i,
   input  logic [XLEN-1:0] alu_res_i,
   input  logic [XLEN-1:0] mem_rdata_i,
   input  logic [XLEN-1:0] pc_i,
   input  logic [XLEN-1:0] imm_i,
   input  logic [2:0]      ld_funct3_i,
   output logic            rf_we_o,
   output logic [4:0]      rf_wr_o,
   output logic [XLEN-1:0] rf_wd_o,
   output logic            wb_valid_o,
   output logic            fwd_we_o,
   output logic [4:0]      fwd_rd_o,
   output logic [XLEN-1:0] fwd_data_o
`ifdef MEM_WB_RETIRE_CNT_EN
   ,
   output logic [63:0]     retire_cnt_o
`endif
);

   mem_wb_t         stage_q, stage_d;
   logic [XLEN-1:0] ld_data;
   logic [XLEN-1:0] wd;
   logic            we;

   always_comb begin
      stage_d = stage_q;
      if (flush_i) begin
         // Flush beats stall: the held entry is turned into a bubble
         stage_d.valid = 1'b0;
         stage_d.wr_en = 1'b0;
      end else if (!stall_i) begin
         stage_d.valid     = valid_i;
         stage_d.wr_en     = wr_en_i;
         stage_d.rd        = rd_i;
         stage_d.wb_sel    = wb_sel_i;
         stage_d.alu_res   = alu_res_i;
         stage_d.mem_rdata = mem_rdata_i;
         stage_d.pc        = pc_i;
         stage_d.imm       = imm_i;
         stage_d.ld_funct3 = ld_funct3_i;
      end
   end

   always_ff @(posedge clk_i) begin
      if (rst_i) stage_q <= '0;
      else       stage_q <= stage_d;
   end

   load_ext u_load_ext (
      .raw_i    (stage_q.mem_rdata),
      .addr_i   (stage_q.alu_res[1:0]),
      .funct3_i (stage_q.ld_funct3),
      .data_o   (ld_data)
   );

   always_comb begin
      wd = stage_q.alu_res;
      unique case (stage_q.wb_sel)
         WB_ALU:  wd = stage_q.alu_res;
         WB_MEM:  wd = ld_data;
         WB_PC4:  wd = stage_q.pc + 32'd4;
         WB_IMM:  wd = stage_q.imm;
         default: wd = stage_q.alu_res;
      endcase
   end

   // x0 writes are suppressed but the entry still counts as valid/retiring
   assign we = stage_q.valid & stage_q.wr_en & (stage_q.rd != 5'd0);

   assign rf_we_o    = we;
   assign rf_wr_o    = stage_q.rd;
   assign rf_wd_o    = wd;
   assign wb_valid_o = stage_q.valid;
   assign fwd_we_o   = we;
   assign fwd_rd_o   = stage_q.rd;
   assign fwd_data_o = wd;

`ifdef MEM_WB_RETIRE_CNT_EN
   logic [63:0] retire_cnt_q, retire_cnt_d;

   // An entry retires once, on the edge where it leaves the stage
   always_comb begin
      retire_cnt_d = retire_cnt_q;
      if (stage_q.valid && !stall_i) retire_cnt_d = retire_cnt_q + 64'd1;
   end

   always_ff @(posedge clk_i) begin
      if (rst_i) retire_cnt_q <= '0;
      else       retire_cnt_q <= retire_cnt_d;
   end

   assign retire_cnt_o = retire_cnt_q;
`endif

endmodule

// File: tb/tb_mem_wb_stage.sv
// Directed testbench for mem_wb_stage. Retire-count checks are active only when
// MEM_WB_RETIRE_CNT_EN is defined.
module tb_mem_wb_stage;
   import cpu_pkg::*;

   logic        clk = 1'b0;
   logic        rst_i, stall_i, flush_i, valid_i, wr_en_i;
   logic [4:0]  rd_i;
   logic [1:0]  wb_sel_i;
   logic [31:0] alu_res_i, mem_rdata_i, pc_i, imm_i;
   logic [2:0]  ld_funct3_i;
   logic        rf_we_o, wb_valid_o, fwd_we_o;
   logic [4:0]  rf_wr_o, fwd_rd_o;
   logic [31:0] rf_wd_o, fwd_data_o;
`ifdef MEM_WB_RETIRE_CNT_EN
   logic [63:0] retire_cnt_o;
`endif

   int errors = 0;
   int checks = 0;
   logic [31:0] rf_model [32];

   always #5 clk = ~clk;

   mem_wb_stage dut (
      .clk_i        (clk),
      .rst_i        (rst_i),
      .stall_i      (stall_i),
      .flush_i      (flush_i),
      .valid_i      (valid_i),
      .wr_en_i      (wr_en_i),
      .rd_i         (rd_i),
      .wb_sel_i     (wb_sel_i),
      .alu_res_i    (alu_res_i),
      .mem_rdata_i  (mem_rdata_i),
      .pc_i         (pc_i),
      .imm_i        (imm_i),
      .ld_funct3_i  (ld_funct3_i),
      .rf_we_o      (rf_we_o),
      .rf_wr_o      (rf_wr_o),
      .rf_wd_o      (rf_wd_o),
      .wb_valid_o   (wb_valid_o),
      .fwd_we_o     (fwd_we_o),
      .fwd_rd_o     (fwd_rd_o),
      .fwd_data_o   (fwd_data_o)
`ifdef MEM_WB_RETIRE_CNT_EN
      ,
      .retire_cnt_o (retire_cnt_o)
`endif
   );

   // Downstream register file: commits on the edge ending the write cycle
   always @(posedge clk) if (rf_we_o) rf_model[rf_wr_o] <= rf_wd_o;

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic drive(input logic v, input logic we, input logic [4:0] rd,
                        input logic [1:0] sel, input logic [31:0] alu,
                        input logic [31:0] mdata, input logic [31:0] pc,
                        input logic [31:0] imm, input logic [2:0] f3);
      valid_i = v; wr_en_i = we; rd_i = rd; wb_sel_i = sel; alu_res_i = alu;
      mem_rdata_i = mdata; pc_i = pc; imm_i = imm; ld_funct3_i = f3;
   endtask

   task automatic do_reset();
      rst_i = 1'b1; stall_i = 1'b0; flush_i = 1'b0;
      drive(1'b0, 1'b0, 5'd0, WB_ALU, 32'd0, 32'd0, 32'd0, 32'd0, LD_W);
      step();
      rst_i = 1'b0;
   endtask

   task automatic test_reset();
      rst_i = 1'b1; stall_i = 1'b0; flush_i = 1'b0;
      drive(1'b1, 1'b1, 5'd9, WB_IMM, 32'h1, 32'h2, 32'h3, 32'h4, LD_W);
      step();
      checks++; if (rf_we_o !== 1'b0) begin errors++; $display("FAIL reset_we: got %b want 0", rf_we_o); end
      checks++; if (wb_valid_o !== 1'b0) begin errors++; $display("FAIL reset_valid: got %b want 0", wb_valid_o); end
      checks++; if (rf_wr_o !== 5'd0 || rf_wd_o !== 32'd0) begin errors++; $display("FAIL reset_port: got wr=%0d wd=%h want 0/0", rf_wr_o, rf_wd_o); end
      checks++; if (fwd_we_o !== 1'b0 || fwd_rd_o !== 5'd0 || fwd_data_o !== 32'd0) begin errors++; $display("FAIL reset_fwd: got %b/%0d/%h want 0/0/0", fwd_we_o, fwd_rd_o, fwd_data_o); end
`ifdef MEM_WB_RETIRE_CNT_EN
      checks++; if (retire_cnt_o !== 64'd0) begin errors++; $display("FAIL reset_cnt: got %0d want 0", retire_cnt_o); end
`endif
      rst_i = 1'b0;
   endtask

   task automatic test_byte_loads();
      drive(1'b1, 1'b1, 5'd5, WB_MEM, 32'h0000_1003, 32'h80FF_7F01, 32'd0, 32'd0, LD_B);
      step();
      checks++; if (rf_we_o !== 1'b1 || rf_wr_o !== 5'd5) begin errors++; $display("FAIL lb_port: got we=%b wr=%0d want 1/5", rf_we_o, rf_wr_o); end
      checks++; if (rf_wd_o !== 32'hFFFF_FF80) begin errors++; $display("FAIL lb_data: got %h want ffffff80", rf_wd_o); end
      drive(1'b1, 1'b1, 5'd5, WB_MEM, 32'h0000_1002, 32'h80FF_7F01, 32'd0, 32'd0, LD_BU);
      step();
      checks++; if (rf_wd_o !== 32'h0000_00FF) begin errors++; $display("FAIL lbu_data: got %h want 000000ff", rf_wd_o); end
      drive(1'b1, 1'b1, 5'd5, WB_MEM, 32'h0000_1001, 32'h80FF_7F01, 32'd0, 32'd0, LD_B);
      step();
      checks++; if (rf_wd_o !== 32'h0000_007F) begin errors++; $display("FAIL lb_pos: got %h want 0000007f", rf_wd_o); end
   endtask

   task automatic test_half_word_loads();
      drive(1'b1, 1'b1, 5'd6, WB_MEM, 32'h0000_0002, 32'h8001_1234, 32'd0, 32'd0, LD_H);
      step();
      checks++; if (rf_wd_o !== 32'hFFFF_8001) begin errors++; $display("FAIL lh_data: got %h want ffff8001", rf_wd_o); end
      drive(1'b1, 1'b1, 5'd6, WB_MEM, 32'h0000_0003, 32'h8001_1234, 32'd0, 32'd0, LD_H);
      step();
      checks++; if (rf_wd_o !== 32'hFFFF_8001) begin errors++; $display("FAIL lh_odd: got %h want ffff8001", rf_wd_o); end
      drive(1'b1, 1'b1, 5'd6, WB_MEM, 32'h0000_0000, 32'h8001_1234, 32'd0, 32'd0, LD_HU);
      step();
      checks++; if (rf_wd_o !== 32'h0000_1234) begin errors++; $display("FAIL lhu_data: got %h want 00001234", rf_wd_o); end
      drive(1'b1, 1'b1, 5'd6, WB_MEM, 32'h0000_0002, 32'h8001_1234, 32'd0, 32'd0, 3'b011);
      step();
      checks++; if (rf_wd_o !== 32'h8001_1234) begin errors++; $display("FAIL ld_other: got %h want 80011234", rf_wd_o); end
      drive(1'b1, 1'b1, 5'd6, WB_IMM, 32'h0000_0002, 32'h8001_1234, 32'd0, 32'hABCD_E000, LD_W);
      step();
      checks++; if (rf_wd_o !== 32'hABCD_E000) begin errors++; $display("FAIL imm_data: got %h want abcde000", rf_wd_o); end
   endtask

   task automatic test_jal_rd0();
      do_reset();
      drive(1'b1, 1'b1, 5'd1, WB_PC4, 32'd0, 32'd0, 32'hFFFF_FFFC, 32'd0, LD_W);
      step();
      checks++; if (rf_we_o !== 1'b1 || rf_wd_o !== 32'h0000_0000) begin errors++; $display("FAIL jal_link: got we=%b wd=%h want 1/00000000", rf_we_o, rf_wd_o); end
      drive(1'b1, 1'b1, 5'd0, WB_PC4, 32'd0, 32'd0, 32'h0000_0100, 32'd0, LD_W);
      step();
      checks++; if (rf_we_o !== 1'b0 || fwd_we_o !== 1'b0) begin errors++; $display("FAIL rd0_we: got we=%b fwd=%b want 0/0", rf_we_o, fwd_we_o); end
      checks++; if (wb_valid_o !== 1'b1) begin errors++; $display("FAIL rd0_valid: got %b want 1", wb_valid_o); end
      drive(1'b0, 1'b0, 5'd0, WB_ALU, 32'd0, 32'd0, 32'd0, 32'd0, LD_W);
      step();
`ifdef MEM_WB_RETIRE_CNT_EN
      // Both the JAL and the rd=0 entry have left the stage
      checks++; if (retire_cnt_o !== 64'd2) begin errors++; $display("FAIL rd0_cnt: got %0d want 2", retire_cnt_o); end
`endif
   endtask

   task automatic test_stall_flush();
      do_reset();
      drive(1'b1, 1'b1, 5'd7, WB_ALU, 32'hA5A5_0000, 32'd0, 32'd0, 32'd0, LD_W);
      step();
      stall_i = 1'b1;
      for (int i = 0; i < 3; i++) begin
         drive(1'b1, 1'b1, 5'(9 + i), WB_ALU, 32'h1234_5678 + i, 32'd0, 32'd0, 32'd0, LD_W);
         step();
         checks++;
         if (rf_we_o !== 1'b1 || rf_wr_o !== 5'd7 || rf_wd_o !== 32'hA5A5_0000) begin
            errors++;
            $display("FAIL stall_hold[%0d]: got we=%b wr=%0d wd=%h want 1/7/a5a50000", i, rf_we_o, rf_wr_o, rf_wd_o);
         end
`ifdef MEM_WB_RETIRE_CNT_EN
         checks++; if (retire_cnt_o !== 64'd0) begin errors++; $display("FAIL stall_cnt[%0d]: got %0d want 0", i, retire_cnt_o); end
`endif
      end
      stall_i = 1'b0;
      drive(1'b0, 1'b0, 5'd0, WB_ALU, 32'd0, 32'd0, 32'd0, 32'd0, LD_W);
      step();
      checks++; if (wb_valid_o !== 1'b0) begin errors++; $display("FAIL stall_release: got valid=%b want 0", wb_valid_o); end
`ifdef MEM_WB_RETIRE_CNT_EN
      checks++; if (retire_cnt_o !== 64'd1) begin errors++; $display("FAIL stall_once: got %0d want 1", retire_cnt_o); end
`endif
      drive(1'b1, 1'b1, 5'd8, WB_ALU, 32'h0000_0BBB, 32'd0, 32'd0, 32'd0, LD_W);
      step();
      checks++; if (rf_we_o !== 1'b1) begin errors++; $display("FAIL flush_setup: got we=%b want 1", rf_we_o); end
      stall_i = 1'b1; flush_i = 1'b1;
      step();
      checks++; if (wb_valid_o !== 1'b0 || rf_we_o !== 1'b0) begin errors++; $display("FAIL flush_over_stall: got valid=%b we=%b want 0/0", wb_valid_o, rf_we_o); end
      stall_i = 1'b0; flush_i = 1'b0;
   endtask

   task automatic test_reset_mid();
      do_reset();
      drive(1'b1, 1'b1, 5'd4, WB_ALU, 32'hDEAD_BEEF, 32'd0, 32'd0, 32'd0, LD_W);
      step();
      step();
      checks++; if (rf_we_o !== 1'b1 || rf_wd_o !== 32'hDEAD_BEEF) begin errors++; $display("FAIL rstmid_setup: got we=%b wd=%h want 1/deadbeef", rf_we_o, rf_wd_o); end
      stall_i = 1'b1; rst_i = 1'b1;
      step();
      rst_i = 1'b0; stall_i = 1'b0;
      checks++; if (rf_we_o !== 1'b0 || wb_valid_o !== 1'b0 || fwd_we_o !== 1'b0) begin errors++; $display("FAIL rstmid_we: got we=%b valid=%b fwd=%b want 0/0/0", rf_we_o, wb_valid_o, fwd_we_o); end
      checks++; if (rf_wr_o !== 5'd0 || rf_wd_o !== 32'd0 || fwd_data_o !== 32'd0) begin errors++; $display("FAIL rstmid_data: got wr=%0d wd=%h fwd=%h want 0/0/0", rf_wr_o, rf_wd_o, fwd_data_o); end
`ifdef MEM_WB_RETIRE_CNT_EN
      checks++; if (retire_cnt_o !== 64'd0) begin errors++; $display("FAIL rstmid_cnt: got %0d want 0", retire_cnt_o); end
`endif
   endtask

   task automatic test_back_to_back();
      do_reset();
      drive(1'b1, 1'b1, 5'd3, WB_ALU, 32'h0000_0011, 32'd0, 32'd0, 32'd0, LD_W);
      step();
      checks++; if (rf_wd_o !== 32'h11 || fwd_data_o !== 32'h11 || fwd_rd_o !== 5'd3) begin errors++; $display("FAIL b2b_first: got wd=%h fwd=%h rd=%0d want 11/11/3", rf_wd_o, fwd_data_o, fwd_rd_o); end
      drive(1'b1, 1'b1, 5'd3, WB_ALU, 32'h0000_0022, 32'd0, 32'd0, 32'd0, LD_W);
      step();
      checks++; if (rf_wd_o !== 32'h22 || fwd_data_o !== 32'h22 || fwd_we_o !== 1'b1) begin errors++; $display("FAIL b2b_second: got wd=%h fwd=%h we=%b want 22/22/1", rf_wd_o, fwd_data_o, fwd_we_o); end
      drive(1'b0, 1'b0, 5'd0, WB_ALU, 32'd0, 32'd0, 32'd0, 32'd0, LD_W);
      step();
      checks++; if (rf_model[3] !== 32'h22) begin errors++; $display("FAIL b2b_rf: got %h want 00000022", rf_model[3]); end
   endtask

   initial begin
      for (int i = 0; i < 32; i++) rf_model[i] = 32'd0;
      test_reset();
      test_byte_loads();
      test_half_word_loads();
      test_jal_rd0();
      test_stall_flush();
      test_reset_mid();
      test_back_to_back();
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule

// File: doc/mem_wb_stage.md
# mem_wb_stage

MEM/WB pipeline register and write-back unit of the pipelined core. It latches results leaving the memory stage and aligns/extends load data. It selects the write-back value and drives the register file write port (write enable, write address, write data). It also exports the same write as a forwarding source for the hazard unit, and optionally counts retired instructions.

## Interface
- No parameters; widths fixed (XLEN 32, 5-bit register index).
- `clk_i` in 1: core clock; all state updates on posedge.
- `rst_i` in 1: reset, synchronous, active-high.
- `stall_i` in 1: hold stage contents.
- `flush_i` in 1: replace incoming entry with a bubble.
- `valid_i` in 1: MEM-stage entry valid.
- `wr_en_i` in 1: instruction writes rd.
- `rd_i` in 5: destination register.
- `wb_sel_i` in 2: write-back source: 00 ALU, 01 load, 10 PC+4, 11 immediate.
- `alu_res_i` in 32: ALU result / effective address.
- `mem_rdata_i` in 32: raw word from data memory.
- `pc_i` in 32: instruction PC.
- `imm_i` in 32: U-type immediate.
- `ld_funct3_i` in 3: load type.
- `rf_we_o` out 1: RF write enable.
- `rf_wr_o` out 5: RF write address.
- `rf_wd_o` out 32: RF write data.
- `wb_valid_o` out 1: stage holds a valid entry.
- `fwd_we_o` / `fwd_rd_o` / `fwd_data_o` out 1/5/32: forwarding copy of the RF write.
- `retire_cnt_o` out 64: retired-instruction count; present only with `MEM_WB_RETIRE_CNT_EN`.

## Operation
- Stage register fields: valid, wr_en, rd, wb_sel, alu_res, mem_rdata, pc, imm, ld_funct3.
- Capture priority per posedge, highest first:
  - rst_i clears all fields to 0.
  - flush_i clears valid and wr_en; flush beats stall.
  - stall_i holds all fields.
  - Otherwise, load the input fields.
- Load extension is combinational from the registered fields. Byte lane is `alu_res[1:0]`; half lane is `alu_res[1]`, and bit 0 is ignored.
  - 000 LB: sign-extend the selected byte.
  - 100 LBU: zero-extend the selected byte.
  - 001 LH: sign-extend the selected half.
  - 101 LHU: zero-extend the selected half.
  - 010 LW and any other code: full word.
- Write data:
  - ALU → alu_res.
  - Load → extended data.
  - PC+4 → pc + 32'd4, modulo 2^32.
  - Immediate → imm.
- `rf_we_o = valid & wr_en & (rd != 0)`. `rf_wr_o = rd`. `rf_wd_o` = selected data, which is meaningful only when `rf_we_o` is high.
- Forwarding outputs mirror `rf_we_o` / `rf_wr_o` / `rf_wd_o` exactly.
- A writing entry with rd = 0 produces no write and no forward, but still retires.
- During a stall, `rf_we_o` stays asserted and the RF rewrites the same value each cycle (idempotent).

## Timing
- Reset value of every output: 0 (`retire_cnt_o` = 0).
- Latency: fields captured at edge N drive the RF write port combinationally during cycle N→N+1; the RF commits at edge N+1.
- No internal combinational path from any input to any output; all outputs depend on registered state only.
- Reset asserted mid-stall or mid-flush discards the entry; no write occurs in the following cycle.
- Reading the same register in the write cycle returns the old RF value. Consumers must use `fwd_*`.

## Configuration
- `MEM_WB_RETIRE_CNT_EN` defined: adds a 64-bit counter.
  - Increments at each posedge where a valid entry leaves the stage (`valid & !stall_i`) and rst_i is low.
  - Counts each entry once regardless of stall length.
  - Wraps from 2^64-1 to 0.
  - Cleared by rst_i.
- Undefined: no counter logic and no `retire_cnt_o` port.

## Structure
- Shared package `cpu_pkg`:
  - wb_sel encodings (WB_ALU, WB_MEM, WB_PC4, WB_IMM).
  - Load funct3 constants (LD_B, LD_H, LD_W, LD_BU, LD_HU).
  - XLEN = 32.
- Sub-module `load_ext`: purely combinational raw word + addr[1:0] + funct3 → extended 32-bit data. Instantiated once.

## Test plan
- **LB lane/sign:** mem_rdata=0x80FF7F01, alu_res=…03, LB, wb_sel=01, rd=5 → next cycle rf_we_o=1, rf_wr_o=5, rf_wd_o=0xFFFFFF80. Same with alu_res=…02 LBU → 0x000000FF.
- **Half/word:** mem_rdata=0x8001_1234, LH at addr …2 → 0xFFFF8001; LHU at addr …0 → 0x00001234; funct3=011 → 0x80011234.
- **JAL link and rd=0:** pc=0xFFFFFFFC, wb_sel=10, rd=1 → rf_wd_o=0x00000000, rf_we_o=1. Same with rd=0 → rf_we_o=0, fwd_we_o=0; retire count +1 (when enabled).
- **Stall/flush priority:** valid entry captured, then stall_i=1 for 3 cycles with changing inputs → outputs unchanged, retire count +1 only once. stall_i=1 and flush_i=1 together → wb_valid_o=0, rf_we_o=0 next cycle.
- **Reset mid-operation:** valid ALU write in stage, rst_i=1 for one edge → all outputs 0 next cycle, including retire_cnt_o.
- **Back-to-back writes:** ALU results 0x11 to x3, then 0x22 to x3 on consecutive cycles → rf_wd_o/fwd_data_o sequence 0x11, 0x22. A downstream RF read of x3 afterward returns 0x22.
